// File: rtl/riscv_pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_stage_reg_pkg
//   Shared definitions for the RV32I inter-stage pipeline register.
//   - XLEN and the typical per-stage payload widths.
//   - occ_e: occupancy encoding driven onto o_occupancy. It is the visible
//     state of the stage: EMPTY, ONE (main slot) or TWO (main + skid slot).
//   - occ_of(): maps the two slot valid bits onto occ_e.
//   Optional feature switch (defined on the tool command line):
//     RISCV_PIPE_SKID_EN - adds the skid slot and registers o_s_ready.
// ---------------------------------------------------------------------------
package riscv_pipe_stage_reg_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IF_ID_W    = 2 * XLEN;  // pc + instruction
  localparam int unsigned ID_EX_W    = 4 * XLEN;  // pc, rs1, rs2, imm
  localparam int unsigned EX_MEM_W   = 3 * XLEN;  // alu result, store data, pc
  localparam int unsigned MEM_WB_W   = 2 * XLEN;  // writeback value, pc

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // The skid slot is only ever filled while the main slot is full, so
  // s_v without m_v cannot occur; it is still mapped to ONE for safety.
  function automatic occ_e occ_of(input logic m_v, input logic s_v);
    if (m_v && s_v) begin
      return OCC_TWO;
    end else if (m_v || s_v) begin
      return OCC_ONE;
    end
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/riscv_pipe_stage_reg_slot.sv
// ---------------------------------------------------------------------------
// riscv_pipe_slot
//   One valid + payload register.
//   Ports:
//     i_clk   clock, rising edge
//     i_clr   clear: valid=0, data=INIT_VAL (reset or flush)
//     i_load  load:  valid=1, data=i_data
//     i_drop  drop:  valid=0, data keeps its last value (no bubble write)
//     i_data  payload to load
//     o_valid slot holds a payload
//     o_data  stored payload
//   Priority: clear > load > drop. With no command the slot holds.
// ---------------------------------------------------------------------------
module riscv_pipe_slot
  import riscv_pipe_stage_reg_pkg::*;
#(
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_drop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_clr) begin
      valid_d = 1'b0;
      data_d  = INIT_VAL;
    end else if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (i_drop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/riscv_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_stage_reg
//   Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   carrying one packed payload with a valid/ready handshake, back-pressure,
//   synchronous flush and a saturating stall-cycle counter.
//
//   Handshake: a beat transfers on a rising edge when valid and ready are
//   both high on that interface. Valid never depends on ready; once
//   o_m_valid is high the payload is held until the downstream beat.
//
//   Parameters:
//     DATA_W    payload width
//     INIT_VAL  payload value loaded on reset/flush
//     CNT_W     stall counter width
//   Ports:
//     i_clk, i_rst        clock; synchronous active-high reset
//     i_flush             synchronous flush (kills held and incoming beats)
//     i_s_valid/o_s_ready/i_s_data  upstream interface
//     o_m_valid/i_m_ready/o_m_data  downstream interface
//     o_occupancy         entries held (0, 1, or 2 with skid)
//     o_stall_cnt         cycles with o_m_valid=1 and i_m_ready=0, saturating
//
//   Build option RISCV_PIPE_SKID_EN:
//     defined   - main slot M plus skid slot S, o_s_ready from a flop
//                 (no combinational path from i_m_ready to o_s_ready).
//     undefined - single slot M, o_s_ready combinational.
// ---------------------------------------------------------------------------
module riscv_pipe_stage_reg
  import riscv_pipe_stage_reg_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  // Reset and flush both empty every slot; only reset touches the counter.
  logic clear;
  assign clear = i_rst | i_flush;

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_load, m_drop;
  logic [DATA_W-1:0] m_load_data;
  logic              s_ready;
  logic              up_beat, dn_beat;
  occ_e              occ;

  assign dn_beat = m_valid & i_m_ready;
  assign up_beat = i_s_valid & s_ready;

`ifdef RISCV_PIPE_SKID_EN
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_load, s_drop;
  logic              s_valid_nxt;
  logic              s_ready_q, s_ready_d;

  // S only accepts a beat while M is held by back-pressure; when M drains,
  // S refills M ahead of any new upstream data, keeping acceptance order.
  always_comb begin
    m_load      = 1'b0;
    m_drop      = 1'b0;
    m_load_data = i_s_data;
    s_load      = 1'b0;
    s_drop      = 1'b0;
    if (s_valid) begin
      if (dn_beat) begin
        m_load      = 1'b1;
        m_load_data = s_data;
        s_drop      = 1'b1;
      end
    end else if (up_beat) begin
      if (m_valid && !i_m_ready) begin
        s_load = 1'b1;
      end else begin
        m_load = 1'b1;
      end
    end else if (dn_beat) begin
      m_drop = 1'b1;
    end
  end

  riscv_pipe_slot #(
    .DATA_W   (DATA_W),
    .INIT_VAL (INIT_VAL)
  ) u_slot_s (
    .i_clk   (i_clk),
    .i_clr   (clear),
    .i_load  (s_load),
    .i_drop  (s_drop),
    .i_data  (i_s_data),
    .o_valid (s_valid),
    .o_data  (s_data)
  );

  // Ready flop mirrors the next-state emptiness of S. It is loaded high
  // on reset so the first cycle after reset is already ready; the i_rst
  // gate keeps the port low while reset is held.
  always_comb begin
    s_valid_nxt = s_valid;
    if (clear) begin
      s_valid_nxt = 1'b0;
    end else if (s_load) begin
      s_valid_nxt = 1'b1;
    end else if (s_drop) begin
      s_valid_nxt = 1'b0;
    end
    s_ready_d = ~s_valid_nxt;
  end

  always_ff @(posedge i_clk) begin
    s_ready_q <= s_ready_d;
  end

  assign s_ready = s_ready_q & ~i_rst;
  assign occ     = occ_of(m_valid, s_valid);
`else
  // Single entry: ready whenever M is empty or draining this cycle.
  assign s_ready = ~i_rst & (~m_valid | i_m_ready);

  always_comb begin
    m_load      = up_beat;
    m_drop      = dn_beat & ~up_beat;
    m_load_data = i_s_data;
  end

  assign occ = occ_of(m_valid, 1'b0);
`endif

  riscv_pipe_slot #(
    .DATA_W   (DATA_W),
    .INIT_VAL (INIT_VAL)
  ) u_slot_m (
    .i_clk   (i_clk),
    .i_clr   (clear),
    .i_load  (m_load),
    .i_drop  (m_drop),
    .i_data  (m_load_data),
    .o_valid (m_valid),
    .o_data  (m_data)
  );

  // Stall counter: saturates at all-ones, survives flush.
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !i_m_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_s_ready   = s_ready;
  assign o_m_valid   = m_valid;
  assign o_m_data    = m_data;
  assign o_occupancy = occ;
  assign o_stall_cnt = stall_cnt_q;

endmodule
